// File: rtl/tr_pkg.sv
// Shared widths, reset values and error-zone classification for the
// tracking-mode stepper controller.
package tr_pkg;

   localparam int unsigned N_W            = 17;
   localparam int unsigned X_W            = 12;
   localparam logic [N_W-1:0] N_RST       = 17'h1FFFF;
   localparam int unsigned N_MIN_DEF      = 500;
   localparam int unsigned GAIN_SHIFT_DEF = 4;

   typedef enum logic [1:0] {
      ZONE_DEAD,
      ZONE_FULL,
      ZONE_PROP
   } zone_t;

   // Deadband wins over full speed; a collapsed band (dx2 <= dx1) means full speed.
   function automatic zone_t classify(input logic [X_W-1:0] a,
                                      input logic [X_W-1:0] dx1,
                                      input logic [X_W-1:0] dx2);
      zone_t z;
      if (a <= dx1)
         z = ZONE_DEAD;
      else if ((a >= dx2) || (dx2 <= dx1))
         z = ZONE_FULL;
      else
         z = ZONE_PROP;
      return z;
   endfunction

endpackage

// File: rtl/tr_step_gen.sv
// Step pulse generator: one clk-wide drv_step every N trigger ticks while enabled.
import tr_pkg::*;

module tr_step_gen (
   input  logic           clk,
   input  logic           rst,
   input  logic           data_valid_trig,
   input  logic           in_drv_enable_SM,
   input  logic [N_W-1:0] N,
   output logic           drv_step
);

   logic [N_W-1:0] cnt;
   logic [N_W-1:0] n_m1;

   // N=0 behaves as N=1, so the terminal count never underflows.
   always_comb begin
      n_m1 = '0;
      if (N != '0)
         n_m1 = N - 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt      <= '0;
         drv_step <= 1'b0;
      end else if (!in_drv_enable_SM) begin
         cnt      <= '0;
         drv_step <= 1'b0;
      end else if (data_valid_trig) begin
         if (cnt >= n_m1) begin
            cnt      <= '0;
            drv_step <= 1'b1;
         end else begin
            cnt      <= cnt + 1'b1;
            drv_step <= 1'b0;
         end
      end else begin
         drv_step <= 1'b0;
      end
   end

endmodule

// File: rtl/tr_track.sv
// Tracking-mode stepper controller: two-stage error/period pipeline feeding
// the step pulse generator.
import tr_pkg::*;

module tr_track #(
   parameter int unsigned N_MIN      = N_MIN_DEF,
   parameter int unsigned GAIN_SHIFT = GAIN_SHIFT_DEF
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           data_valid,
   input  logic           data_valid_trig,
   input  logic           tr_mode_enable,
   input  logic [X_W-1:0] x,
   input  logic [X_W-1:0] x0,
   input  logic [X_W-1:0] dx1,
   input  logic [X_W-1:0] dx2,
   output logic           drv_step,
   output logic           drv_dir,
   output logic           drv_enable_SM,
   output logic [N_W-1:0] N
);

   logic signed [X_W:0] e;
   logic [X_W-1:0]      a_c;
   logic                sign_c;
   logic                take;

   logic [X_W-1:0]      a_r;
   logic                sign_r;
   logic                v1;

   zone_t               zone;
   logic [X_W-1:0]      gap;
   logic [31:0]         n_wide;
   logic [N_W-1:0]      n_prop;

   assign take   = data_valid && tr_mode_enable;
   assign e      = $signed({1'b0, x}) - $signed({1'b0, x0});
   assign a_c    = e[X_W] ? X_W'(-e) : X_W'(e);
   assign sign_c = !e[X_W] && (e != '0);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         a_r    <= '0;
         sign_r <= 1'b0;
         v1     <= 1'b0;
      end else begin
         v1 <= take;
         if (take) begin
            a_r    <= a_c;
            sign_r <= sign_c;
         end
      end
   end

   // Proportional period computed 32 bits wide so saturation sees the true sum.
   always_comb begin
      zone   = classify(a_r, dx1, dx2);
      gap    = dx2 - a_r;
      n_wide = N_MIN + ({{(32-X_W){1'b0}}, gap} << GAIN_SHIFT);
      n_prop = N_RST;
      if (n_wide <= 32'(N_RST))
         n_prop = n_wide[N_W-1:0];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         drv_enable_SM <= 1'b0;
         drv_dir       <= 1'b0;
         N             <= N_RST;
      end else if (!tr_mode_enable) begin
         drv_enable_SM <= 1'b0;
      end else if (v1) begin
         case (zone)
            ZONE_DEAD: drv_enable_SM <= 1'b0;
            ZONE_FULL: begin
               drv_enable_SM <= 1'b1;
               drv_dir       <= sign_r;
               N             <= N_W'(N_MIN);
            end
            default: begin
               drv_enable_SM <= 1'b1;
               drv_dir       <= sign_r;
               N             <= n_prop;
            end
         endcase
      end
   end

   tr_step_gen u_step (
      .clk              (clk),
      .rst              (rst),
      .data_valid_trig  (data_valid_trig),
      .in_drv_enable_SM (drv_enable_SM),
      .N                (N),
      .drv_step         (drv_step)
   );

endmodule

// File: tb/tb_tr_track.sv
// Self-checking bench for tr_track: directed scenarios plus randomized samples
// against an arithmetic reference model.
`timescale 1ns/1ps

module tb_tr_track;
   import tr_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        data_valid = 1'b0;
   logic        data_valid_trig = 1'b0;
   logic        tr_mode_enable = 1'b0;
   logic [11:0] x = '0, x0 = '0, dx1 = '0, dx2 = '0;
   logic        drv_step, drv_dir, drv_enable_SM;
   logic [16:0] N;

   int n_assert = 0;
   int n_fail   = 0;

   always #10 clk = ~clk;

   tr_track #(.N_MIN(500), .GAIN_SHIFT(4)) dut (
      .clk             (clk),
      .rst             (rst),
      .data_valid      (data_valid),
      .data_valid_trig (data_valid_trig),
      .tr_mode_enable  (tr_mode_enable),
      .x               (x),
      .x0              (x0),
      .dx1             (dx1),
      .dx2             (dx2),
      .drv_step        (drv_step),
      .drv_dir         (drv_dir),
      .drv_enable_SM   (drv_enable_SM),
      .N               (N)
   );

   // tick generator: one tick every 5 clk while tick_on
   bit tick_on = 1'b0;
   initial begin
      int ph;
      ph = 0;
      forever begin
         @(posedge clk);
         #1;
         if (tick_on) begin
            ph = (ph + 1) % 5;
            data_valid_trig = (ph == 0);
         end else begin
            ph = 0;
            data_valid_trig = 1'b0;
         end
      end
   end

   // monitor: step times, ticks counted while enabled, pulse widths
   int  cyc = 0;
   int  step_cnt = 0;
   int  ticks = 0;
   int  wide_cnt = 0;
   int  step_cyc[$];
   int  step_ticks[$];
   bit  prev_step = 1'b0;
   always @(negedge clk) begin
      cyc++;
      if (drv_step === 1'b1) begin
         step_cnt++;
         step_cyc.push_back(cyc);
         step_ticks.push_back(ticks);
         ticks = 0;
         if (prev_step) wide_cnt++;
      end
      prev_step = (drv_step === 1'b1);
      if (drv_enable_SM !== 1'b1)
         ticks = 0;
      else if (data_valid_trig)
         ticks++;
   end

   // reference model
   logic [16:0] m_N   = 17'h1FFFF;
   logic        m_dir = 1'b0;
   logic        m_en  = 1'b0;

   task automatic model(input int xv, input int x0v, input int d1, input int d2);
      int e, a, n;
      e = xv - x0v;
      a = (e < 0) ? -e : e;
      if (a <= d1) begin
         m_en = 1'b0;
      end else begin
         m_en  = 1'b1;
         m_dir = (e > 0);
         if (a >= d2 || d2 <= d1) begin
            m_N = 17'd500;
         end else begin
            n   = 500 + (d2 - a) * 16;
            m_N = (n > 131071) ? 17'h1FFFF : 17'(n);
         end
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic sample(input logic [11:0] xv);
      x = xv;
      data_valid = 1'b1;
      @(posedge clk);
      #1;
      data_valid = 1'b0;
      @(posedge clk);
      #1;
      model(int'(xv), int'(x0), int'(dx1), int'(dx2));
   endtask

   task automatic check_out(input string tag);
      check({tag, "_en"},  32'(drv_enable_SM), 32'(m_en));
      check({tag, "_dir"}, 32'(drv_dir),       32'(m_dir));
      check({tag, "_N"},   32'(N),             32'(m_N));
   endtask

   task automatic wait_steps(input int target, input int budget, input string tag);
      int k;
      k = 0;
      while (step_cyc.size() < target && k < budget) begin
         @(posedge clk);
         k++;
      end
      #1;
      check({tag, "_timeout"}, 32'(step_cyc.size() >= target), 32'd1);
   endtask

   initial begin
      int s0, q0, en_seen;

      // 1: reset values, then disabled mode ignores samples
      repeat (3) @(posedge clk);
      #1;
      check("rst_step", 32'(drv_step), 32'd0);
      check("rst_dir",  32'(drv_dir), 32'd0);
      check("rst_en",   32'(drv_enable_SM), 32'd0);
      check("rst_N",    32'(N), 32'h1FFFF);
      rst = 1'b1;
      x0 = 12'd10; dx1 = 12'd150; dx2 = 12'd1500; x = 12'd2000;
      tick_on = 1'b1;
      s0 = step_cnt;
      en_seen = 0;
      repeat (20) begin
         data_valid = ~data_valid;
         @(posedge clk);
         #1;
         if (drv_enable_SM !== 1'b0) en_seen++;
      end
      data_valid = 1'b0;
      check("dis_en", 32'(en_seen), 32'd0);
      check("dis_steps", 32'(step_cnt - s0), 32'd0);

      // 2: inside deadband
      tr_mode_enable = 1'b1;
      sample(12'd100);
      check_out("t2");
      s0 = step_cnt;
      repeat (200) @(posedge clk);
      #1;
      check("t2_steps", 32'(step_cnt - s0), 32'd0);

      // 3: full speed, step spacing
      q0 = step_cyc.size();
      sample(12'd2000);
      check_out("t3");
      check("t3_N500", 32'(N), 32'd500);
      wait_steps(q0 + 3, 10000, "t3");
      check("t3_first_ticks", 32'(step_ticks[q0]), 32'd500);
      check("t3_period1", 32'(step_cyc[q0+1] - step_cyc[q0]), 32'd2500);
      check("t3_period2", 32'(step_cyc[q0+2] - step_cyc[q0+1]), 32'd2500);
      check("t3_width", 32'(wide_cnt), 32'd0);

      // 4: proportional zone
      sample(12'd1000);
      check_out("t4");
      check("t4_N8660", 32'(N), 32'd8660);

      // 5: negative error, then deadband hold
      x0 = 12'd2000;
      sample(12'd100);
      check_out("t5a");
      sample(12'd1990);
      check_out("t5b");
      check("t5b_N_hold", 32'(N), 32'd500);

      // 6: drop tracking mode mid-count, then re-enable
      x0 = 12'd10;
      q0 = step_cyc.size();
      sample(12'd2000);
      check_out("t6");
      wait_steps(q0 + 1, 3000, "t6a");
      repeat (100) @(posedge clk);
      #1;
      tr_mode_enable = 1'b0;
      @(posedge clk);
      #1;
      check("t6_en_off", 32'(drv_enable_SM), 32'd0);
      s0 = step_cnt;
      repeat (3000) @(posedge clk);
      #1;
      check("t6_no_steps", 32'(step_cnt - s0), 32'd0);
      check("t6_cnt_clear", 32'(dut.u_step.cnt), 32'd0);
      tr_mode_enable = 1'b1;
      q0 = step_cyc.size();
      sample(12'd2000);
      check_out("t6r");
      wait_steps(q0 + 1, 3000, "t6b");
      check("t6_reen_ticks", 32'(step_ticks[q0]), 32'd500);
      check("t6_width", 32'(wide_cnt), 32'd0);

      // randomized samples against the model
      tick_on = 1'b0;
      repeat (24) begin
         x0  = 12'($urandom_range(0, 4095));
         dx1 = 12'($urandom_range(0, 2000));
         dx2 = 12'($urandom_range(0, 3000));
         sample(12'($urandom_range(0, 4095)));
         check_out("rnd");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
